l_addsub_sat_pipe: RTL

//  Parametrised saturating add/subtract for fixed-point datapaths. Adds a per-sample

---
 rtl/l_addsub_sat_pipe_pkg.sv | 24 ++
 rtl/l_pipe_stage.sv | 45 ++++
 rtl/l_addsub_sat_pipe.sv | 115 +++++++++++
 3 files changed

// File: rtl/l_addsub_sat_pipe_pkg.sv
// Shared fixed-point definitions for the saturating add/sub datapath.
package l_addsub_sat_pipe_pkg;

    // Per-sample operation select (sub input)
    typedef enum logic {
        OpAdd = 1'b0,
        OpSub = 1'b1
    } addsub_op_e;

    // Overflow handling mode (sat_en input), shared with the other fxp blocks
    typedef enum logic {
        ModeWrap = 1'b0,
        ModeSat  = 1'b1
    } sat_mode_e;

    localparam int unsigned MinStages = 1;
    localparam int unsigned MaxStages = 4;

    // Two's complement overflow: the guard bit disagrees with the result sign
    function automatic logic ovf_detect(input logic guard_bit, input logic sign_bit);
        return guard_bit ^ sign_bit;
    endfunction

endpackage

// File: rtl/l_pipe_stage.sv
// One valid/ready register slice: holds data while stalled, no skid buffer.
module l_pipe_stage #(
    parameter int unsigned DW = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          next_advance,
    output logic          advance,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    assign advance   = ~valid_q | next_advance;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load a new sample (or a bubble) when advancing; otherwise hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // Slice register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/l_addsub_sat_pipe.sv
// Saturating/wrapping add-subtract with a valid/ready pipeline and overflow status.
module l_addsub_sat_pipe
    import l_addsub_sat_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             overflow,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    localparam int unsigned DW = WIDTH + 1;
    localparam logic [WIDTH-1:0] FxpMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] FxpMin = {1'b1, {(WIDTH-1){1'b0}}};

    addsub_op_e op;
    sat_mode_e  mode;
    logic [WIDTH:0]   a_ext, b_ext, sum;
    logic             ovf;
    logic [WIDTH-1:0] res;

    assign op   = addsub_op_e'(sub);
    assign mode = sat_mode_e'(sat_en);

    // Sign-extend by one guard bit, add or subtract, then saturate if enabled
    always_comb begin
        a_ext = {a[WIDTH-1], a};
        b_ext = {b[WIDTH-1], b};
        sum   = (op == OpSub) ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf   = ovf_detect(sum[WIDTH], sum[WIDTH-1]);
        res   = sum[WIDTH-1:0];
        if (ovf && (mode == ModeSat)) begin
            res = sum[WIDTH] ? FxpMin : FxpMax;
        end
    end

    // Pipeline chain; index 0 is the input side, index STAGES the output side
    logic [STAGES:0] stg_valid;
    logic [STAGES:0] stg_adv;
    logic [DW-1:0]   stg_data [STAGES+1];

    assign stg_valid[0]    = in_valid;
    assign stg_data[0]     = {ovf, res};
    assign stg_adv[STAGES] = out_ready;
    assign in_ready        = stg_adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        l_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (stg_valid[k]),
            .in_data      (stg_data[k]),
            .next_advance (stg_adv[k+1]),
            .advance      (stg_adv[k]),
            .out_valid    (stg_valid[k+1]),
            .out_data     (stg_data[k+1])
        );
    end

    assign out_valid       = stg_valid[STAGES];
    assign {overflow, c}   = stg_data[STAGES];

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             xfer_ovf;

    assign xfer_ovf   = out_valid && out_ready && overflow;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

    // Status follows output transfers; an overflow transfer beats a concurrent clear
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (xfer_ovf) begin
            sticky_d = 1'b1;
            if (ovf_clr) begin
                count_d = CNT_W'(1);
            end else if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (ovf_clr) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    // Status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

endmodule
